// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI mode-0 target.
package spi_pkg;

    localparam int SPI_BYTE_W    = 8;
    localparam int SPI_BIT_CNT_W = 3;

    localparam logic [SPI_BYTE_W-1:0] SPI_FILL_DEFAULT = 8'hFF;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI input, followed by an
// edge-detect flop; level/rise/fall are all relative to the synchronised value.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    // Next values for the synchroniser chain and edge-detect flop.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_d};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Synchroniser and edge-detect registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign o_level = sync_q[SYNC_STAGES-1];
    assign o_rise  = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign o_fall  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: oversampled receive/transmit with a one-entry tx holding register.
// Optional macro SPI_TARGET_FRAME_COUNT_EN adds o_frame_count (full bytes in current frame).
module spi_target
    import spi_pkg::*;
#(
    parameter logic [SPI_BYTE_W-1:0] FILL        = SPI_FILL_DEFAULT,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cs,
    input  logic                  i_sclk,
    input  logic                  i_copi,
    output logic                  o_cipo,
    output logic                  o_cipo_oe,
    output logic [SPI_BYTE_W-1:0] o_rx_data,
    output logic                  o_rx_valid,
    input  logic [SPI_BYTE_W-1:0] i_tx_data,
    input  logic                  i_tx_valid,
    output logic                  o_tx_ready,
    output logic                  o_underrun,
    output logic                  o_busy
`ifdef SPI_TARGET_FRAME_COUNT_EN
    ,
    output logic [7:0]            o_frame_count
`endif
);

    logic cs_level_s, cs_rise_s, cs_fall_s;
    logic sclk_level_s, sclk_rise_s, sclk_fall_s;
    logic copi_level_s, copi_rise_s, copi_fall_s;
    logic sync_unused_s;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(i_cs),
        .o_level(cs_level_s), .o_rise(cs_rise_s), .o_fall(cs_fall_s)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(i_sclk),
        .o_level(sclk_level_s), .o_rise(sclk_rise_s), .o_fall(sclk_fall_s)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_copi_sync (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(i_copi),
        .o_level(copi_level_s), .o_rise(copi_rise_s), .o_fall(copi_fall_s)
    );

    assign sync_unused_s = ^{cs_level_s, sclk_level_s, copi_rise_s, copi_fall_s};

    spi_state_e               state_q, state_d;
    logic [SPI_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [SPI_BYTE_W-1:0]    rx_shift_q, rx_shift_d;
    logic [SPI_BYTE_W-1:0]    tx_shift_q, tx_shift_d;
    logic [SPI_BYTE_W-1:0]    hold_q, hold_d;
    logic                     tx_ready_q, tx_ready_d;
    logic [SPI_BYTE_W-1:0]    rx_data_q, rx_data_d;
    logic                     rx_valid_q, rx_valid_d;
    logic                     underrun_q, underrun_d;
    logic                     cipo_q, cipo_d;
    logic                     cipo_oe_q, cipo_oe_d;
    logic                     busy_q, busy_d;
    logic                     load_s;
`ifdef SPI_TARGET_FRAME_COUNT_EN
    logic [7:0]               frame_cnt_q, frame_cnt_d;
`endif

    // Next-state, shift and holding-register logic.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        hold_d     = hold_q;
        tx_ready_d = tx_ready_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        underrun_d = 1'b0;
        cipo_d     = cipo_q;
        cipo_oe_d  = cipo_oe_q;
        busy_d     = busy_q;
        load_s     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall_s) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = 3'd0;
                    busy_d    = 1'b1;
                    cipo_oe_d = 1'b1;
                    load_s    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // CS deselect takes priority over any SCLK edge seen in the same cycle.
                if (cs_rise_s) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = 3'd0;
                    cipo_oe_d = 1'b0;
                    cipo_d    = 1'b1;
                    busy_d    = 1'b0;
                end else if (sclk_rise_s) begin
                    rx_shift_d = {rx_shift_q[SPI_BYTE_W-2:0], copi_level_s};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d  = {rx_shift_q[SPI_BYTE_W-2:0], copi_level_s};
                        rx_valid_d = 1'b1;
                    end else begin
                        rx_valid_d = 1'b0;
                    end
                end else if (sclk_fall_s) begin
                    if (bit_cnt_q != 3'd0) begin
                        tx_shift_d = {tx_shift_q[SPI_BYTE_W-2:0], 1'b0};
                        cipo_d     = tx_shift_q[SPI_BYTE_W-2];
                    end else begin
                        load_s = 1'b1;
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = 3'd0;
                cipo_oe_d = 1'b0;
                cipo_d    = 1'b1;
                busy_d    = 1'b0;
            end
        endcase

        if (load_s && !tx_ready_q) begin
            tx_shift_d = hold_q;
            cipo_d     = hold_q[SPI_BYTE_W-1];
            tx_ready_d = 1'b1;
        end else if (load_s) begin
            tx_shift_d = FILL;
            cipo_d     = FILL[SPI_BYTE_W-1];
            underrun_d = 1'b1;
        end else begin
            underrun_d = 1'b0;
        end

        // A write is accepted only while empty; a same-cycle load has already taken the old value.
        if (i_tx_valid && tx_ready_q) begin
            hold_d     = i_tx_data;
            tx_ready_d = 1'b0;
        end else begin
            hold_d = hold_q;
        end
    end

`ifdef SPI_TARGET_FRAME_COUNT_EN
    // Per-frame count of completed bytes, saturating.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (state_q == ST_IDLE && cs_fall_s) begin
            frame_cnt_d = 8'd0;
        end else if (rx_valid_d && frame_cnt_q != 8'd255) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Frame counter register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            frame_cnt_q <= 8'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign o_frame_count = frame_cnt_q;
`endif

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            rx_shift_q <= 8'd0;
            tx_shift_q <= 8'd0;
            hold_q     <= 8'd0;
            tx_ready_q <= 1'b1;
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            cipo_q     <= 1'b1;
            cipo_oe_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            hold_q     <= hold_d;
            tx_ready_q <= tx_ready_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            underrun_q <= underrun_d;
            cipo_q     <= cipo_d;
            cipo_oe_q  <= cipo_oe_d;
            busy_q     <= busy_d;
        end
    end

    assign o_cipo     = cipo_q;
    assign o_cipo_oe  = cipo_oe_q;
    assign o_rx_data  = rx_data_q;
    assign o_rx_valid = rx_valid_q;
    assign o_tx_ready = tx_ready_q;
    assign o_underrun = underrun_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_spi_target.sv
// Randomised bench for spi_target against a byte-level model of the SPI target.
module tb_spi_target;

    logic       i_clk = 1'b0;
    logic       i_rst, i_cs, i_sclk, i_copi;
    logic       o_cipo, o_cipo_oe, o_rx_valid, o_tx_ready, o_underrun, o_busy;
    logic [7:0] o_rx_data, i_tx_data;
    logic       i_tx_valid;
`ifdef SPI_TARGET_FRAME_COUNT_EN
    logic [7:0] o_frame_count;
`endif

    spi_target dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_cs(i_cs), .i_sclk(i_sclk), .i_copi(i_copi),
        .o_cipo(o_cipo), .o_cipo_oe(o_cipo_oe), .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid),
        .i_tx_data(i_tx_data), .i_tx_valid(i_tx_valid), .o_tx_ready(o_tx_ready),
        .o_underrun(o_underrun), .o_busy(o_busy)
`ifdef SPI_TARGET_FRAME_COUNT_EN
        , .o_frame_count(o_frame_count)
`endif
    );

    always #5 i_clk = ~i_clk;

    int         n_checks = 0;
    int         n_bad    = 0;
    logic [7:0] rx_q[$];
    int         ur_cnt   = 0;
    logic [7:0] mosi [0:7];
    logic       m_full   = 1'b0;
    logic [7:0] m_hold   = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Record every received byte and underrun pulse.
    always @(negedge i_clk) begin
        if (o_rx_valid) rx_q.push_back(o_rx_data);
        if (o_underrun) ur_cnt++;
    end

    task automatic tx_write(input logic [7:0] d);
        @(negedge i_clk);
        i_tx_valid = 1'b1;
        i_tx_data  = d;
        if (!m_full) begin
            m_full = 1'b1;
            m_hold = d;
        end
        @(negedge i_clk);
        i_tx_valid = 1'b0;
    endtask

    // One CS frame: nbytes bytes from mosi[], the last one cut to last_bits bits.
    task automatic run_frame(input int nbytes, input int last_bits);
        logic [7:0] exp_miso [0:7];
        logic [7:0] got;
        int nb, rx_base, ur_base, exp_ur, full_bytes;
        rx_base = rx_q.size();
        ur_base = ur_cnt;
        exp_ur  = 0;
        for (int b = 0; b < nbytes; b++) begin
            if (m_full) begin
                exp_miso[b] = m_hold;
                m_full      = 1'b0;
            end else begin
                exp_miso[b] = 8'hFF;
                exp_ur++;
            end
        end
        full_bytes = (last_bits == 8) ? nbytes : nbytes - 1;

        @(negedge i_clk);
        i_cs = 1'b0;
        repeat (8) @(negedge i_clk);
        chk("busy_in_frame", 32'(o_busy), 32'd1);
        chk("oe_in_frame", 32'(o_cipo_oe), 32'd1);
`ifdef SPI_TARGET_FRAME_COUNT_EN
        chk("fcnt_clear", 32'(o_frame_count), 32'd0);
`endif
        for (int b = 0; b < nbytes; b++) begin
            nb  = (b == nbytes - 1) ? last_bits : 8;
            got = 8'h00;
            for (int k = 0; k < nb; k++) begin
                i_copi = mosi[b][7-k];
                repeat (4) @(negedge i_clk);
                i_sclk = 1'b1;
                got    = {got[6:0], o_cipo};
                repeat (4) @(negedge i_clk);
                i_sclk = 1'b0;
                // CS rises together with the final SCLK fall, so no extra byte is loaded.
                if (b == nbytes - 1 && k == nb - 1) i_cs = 1'b1;
            end
            chk("cipo_byte", 32'(got), 32'(exp_miso[b] >> (8 - nb)));
        end
        repeat (10) @(negedge i_clk);

        chk("rx_count", 32'(rx_q.size() - rx_base), 32'(full_bytes));
        for (int b = 0; b < full_bytes; b++) begin
            if (rx_base + b < rx_q.size())
                chk("rx_byte", 32'(rx_q[rx_base+b]), 32'(mosi[b]));
        end
        chk("underruns", 32'(ur_cnt - ur_base), 32'(exp_ur));
        chk("ready_after", 32'(o_tx_ready), 32'(!m_full));
        chk("oe_after", 32'(o_cipo_oe), 32'd0);
        chk("busy_after", 32'(o_busy), 32'd0);
        chk("cipo_idle", 32'(o_cipo), 32'd1);
        if (full_bytes > 0) chk("rx_data_hold", 32'(o_rx_data), 32'(mosi[full_bytes-1]));
`ifdef SPI_TARGET_FRAME_COUNT_EN
        chk("fcnt", 32'(o_frame_count), 32'(full_bytes));
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nbytes, last_bits;
        i_rst = 1'b1; i_cs = 1'b1; i_sclk = 1'b0; i_copi = 1'b0;
        i_tx_valid = 1'b0; i_tx_data = 8'h00;
        repeat (5) @(negedge i_clk);
        i_rst = 1'b0;

        // Idle after reset: nothing should move.
        for (int c = 0; c < 100; c++) begin
            @(negedge i_clk);
            chk("idle_oe", 32'(o_cipo_oe), 32'd0);
            chk("idle_cipo", 32'(o_cipo), 32'd1);
            chk("idle_ready", 32'(o_tx_ready), 32'd1);
        end
        chk("idle_rx_count", 32'(rx_q.size()), 32'd0);
        chk("idle_rx_data", 32'(o_rx_data), 32'd0);
        chk("idle_busy", 32'(o_busy), 32'd0);

        tx_write(8'h3C);
        chk("ready_low_after_write", 32'(o_tx_ready), 32'd0);
        mosi[0] = 8'hA5;
        run_frame(1, 8);

        tx_write(8'h77);
        mosi[0] = 8'h01; mosi[1] = 8'h02; mosi[2] = 8'h03;
        run_frame(3, 8);

        mosi[0] = 8'hF0;
        run_frame(1, 5);
        mosi[0] = 8'h81;
        run_frame(1, 8);

        // Second write while not ready is dropped.
        @(negedge i_clk);
        i_tx_valid = 1'b1; i_tx_data = 8'h11;
        m_full = 1'b1; m_hold = 8'h11;
        @(negedge i_clk);
        i_tx_data = 8'h22;
        @(negedge i_clk);
        i_tx_valid = 1'b0;
        chk("ready_after_pair", 32'(o_tx_ready), 32'd0);
        mosi[0] = 8'h5E; mosi[1] = 8'hC3;
        run_frame(2, 8);

        mosi[0] = 8'h12; mosi[1] = 8'h34; mosi[2] = 8'h56; mosi[3] = 8'h78;
        run_frame(4, 8);

        // Reset in the middle of a frame.
        tx_write(8'h5A);
        @(negedge i_clk);
        i_cs = 1'b0;
        m_full = 1'b0;
        repeat (8) @(negedge i_clk);
        for (int k = 0; k < 3; k++) begin
            i_copi = k[0];
            repeat (4) @(negedge i_clk);
            i_sclk = 1'b1;
            repeat (4) @(negedge i_clk);
            i_sclk = 1'b0;
        end
        tx_write(8'h6B);
        chk("ready_mid_frame", 32'(o_tx_ready), 32'd0);
        i_rst = 1'b1; i_cs = 1'b1; i_sclk = 1'b0;
        @(negedge i_clk);
        chk("rst_oe", 32'(o_cipo_oe), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_cipo", 32'(o_cipo), 32'd1);
        chk("rst_ready", 32'(o_tx_ready), 32'd1);
        chk("rst_rx_data", 32'(o_rx_data), 32'd0);
        m_full = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        repeat (5) @(negedge i_clk);

        for (int f = 0; f < 30; f++) begin
            if ($urandom_range(0, 1) == 1) tx_write(8'($urandom));
            nbytes    = $urandom_range(1, 4);
            last_bits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
            for (int b = 0; b < nbytes; b++) mosi[b] = 8'($urandom);
            run_frame(nbytes, last_bits);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
